// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and encodings for the pipeline stall/flush controller.
//   fence_state_t : fence sequencing FSM states (IDLE=0, DRAIN=1, RESUME=2)
//   REDIR_*       : encodings of the fetch-unit PC select driven on redirect_sel
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RESUME = 2'd2
    } fence_state_t;

    localparam logic [1:0] REDIR_SEQ   = 2'd0;  // sequential / predicted PC
    localparam logic [1:0] REDIR_BR    = 2'd1;  // EXE-resolved branch target
    localparam logic [1:0] REDIR_TRAP  = 2'd2;  // trap vector
    localparam logic [1:0] REDIR_FENCE = 2'd3;  // instruction after the fence

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
// Purely combinational load-use hazard detector: the ID instruction reads a
// register that the load currently in EXE has not yet produced.
// Ports:
//   is_load_exe, rd_exe           : EXE instruction is a load / its destination
//   rs1_id, rs2_id                : ID source register indices
//   rs1_used_id, rs2_used_id      : ID instruction actually reads that source
//   hazard                        : 1 when ID must wait one cycle for the load
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              is_load_exe,
    input  logic [REG_AW-1:0] rd_exe,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    output logic              hazard
);

    logic [1:0][REG_AW-1:0] rs_id;
    logic [1:0]             rs_used;
    logic [1:0]             src_match;

    assign rs_id   = {rs2_id, rs1_id};
    assign rs_used = {rs2_used_id, rs1_used_id};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = rs_used[gi] && (rs_id[gi] == rd_exe);
        end
    endgenerate

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard = is_load_exe && (rd_exe != '0) && (|src_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the five-stage pipeline. Every cycle one
// event wins by fixed priority (trap, memory wait, mispredict, fence, load-use,
// fetch wait) and only that event drives stall/flush/redirect. A three-state
// FSM sequences fence drain and the refetch after it.
// Ports:
//   clk, rst (sync, active-high)
//   if_busy, mem_busy               : fetch / data-memory wait states
//   is_load_exe, rd_exe, rs*_id,
//   rs*_used_id                     : load-use hazard inputs
//   mispredict_exe, fence_exe       : EXE-resolved control events
//   trap_wb                         : exception / xRET committing in WB
//   valid_mem, valid_wb             : occupancy of MEM and WB (drain test)
//   stall_* / flush_*               : per-register hold / bubble controls
//   redirect_sel                    : fetch PC select (see pipe_ctrl_pkg REDIR_*)
//   fence_busy                      : fence FSM not idle
// Optional build macro PIPE_HAZARD_PERF_EN adds two 32-bit saturating counters:
//   perf_stall_cycles (cycles with stall_if), perf_flush_events (cycles with any flush)
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              is_load_exe,
    input  logic [REG_AW-1:0] rd_exe,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic              mispredict_exe,
    input  logic              fence_exe,
    input  logic              trap_wb,
    input  logic              valid_mem,
    input  logic              valid_wb,
    output logic              stall_if,
    output logic              stall_ifid,
    output logic              stall_idexe,
    output logic              stall_exemem,
    output logic              stall_memwb,
    output logic              flush_ifid,
    output logic              flush_idexe,
    output logic              flush_exemem,
    output logic              flush_memwb,
    output logic [1:0]        redirect_sel,
    output logic              fence_busy
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flush_events
`endif
);

    fence_state_t state_reg;
    fence_state_t state_next;
    logic         load_use;

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .is_load_exe (is_load_exe),
        .rd_exe      (rd_exe),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used_id (rs1_used_id),
        .rs2_used_id (rs2_used_id),
        .hazard      (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Single priority chain: the first matching event owns all outputs.
    // The FSM only moves when fence handling wins (or a trap aborts it);
    // higher-priority events simply hold it where it is.
    always_comb begin
        stall_if     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idexe  = 1'b0;
        stall_exemem = 1'b0;
        stall_memwb  = 1'b0;  // nothing in this pipeline ever holds MEM/WB
        flush_ifid   = 1'b0;
        flush_idexe  = 1'b0;
        flush_exemem = 1'b0;
        flush_memwb  = 1'b0;
        redirect_sel = REDIR_SEQ;
        state_next   = state_reg;

        if (rst) begin
            state_next = ST_IDLE;
        end else if (trap_wb) begin
            flush_ifid   = 1'b1;
            flush_idexe  = 1'b1;
            flush_exemem = 1'b1;
            flush_memwb  = 1'b1;
            redirect_sel = REDIR_TRAP;
            state_next   = ST_IDLE;
        end else if (mem_busy) begin
            // Freeze everything up to MEM; WB receives a bubble.
            stall_if     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idexe  = 1'b1;
            stall_exemem = 1'b1;
            flush_memwb  = 1'b1;
        end else if (mispredict_exe) begin
            flush_ifid   = 1'b1;
            flush_idexe  = 1'b1;
            redirect_sel = REDIR_BR;
        end else if (state_reg == ST_DRAIN) begin
            stall_if   = 1'b1;
            flush_ifid = 1'b1;
            // mem_busy is already known to be 0 on this branch.
            if (!valid_mem && !valid_wb) begin
                state_next = ST_RESUME;
            end
        end else if (state_reg == ST_RESUME) begin
            redirect_sel = REDIR_FENCE;
            state_next   = ST_IDLE;
        end else if (fence_exe) begin
            stall_if    = 1'b1;
            flush_ifid  = 1'b1;
            flush_idexe = 1'b1;
            state_next  = ST_DRAIN;
        end else if (load_use) begin
            stall_if    = 1'b1;
            stall_ifid  = 1'b1;
            flush_idexe = 1'b1;
        end else if (if_busy) begin
            stall_if   = 1'b1;
            flush_ifid = 1'b1;
        end
    end

    assign fence_busy = !rst && (state_reg != ST_IDLE);

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles_reg;
    logic [31:0] perf_flush_events_reg;
    logic        any_flush;

    assign any_flush = flush_ifid | flush_idexe | flush_exemem | flush_memwb;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles_reg <= '0;
            perf_flush_events_reg <= '0;
        end else begin
            if (stall_if && (perf_stall_cycles_reg != '1)) begin
                perf_stall_cycles_reg <= perf_stall_cycles_reg + 32'd1;
            end
            if (any_flush && (perf_flush_events_reg != '1)) begin
                perf_flush_events_reg <= perf_flush_events_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_cycles_reg;
    assign perf_flush_events = perf_flush_events_reg;
`endif

endmodule
